// File: rtl/spdif_bmc_encoder_if.sv
// Sample-pair handshake between the PCM source and the S/PDIF transmitter.
// A transfer happens on a clk edge where i_valid and o_ready are both high.
interface spdif_bmc_encoder_if #(
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] i_left;
    logic [DATA_W-1:0] i_right;
    logic              i_valid;
    logic              o_ready;

    modport master (
        output i_left,
        output i_right,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_left,
        input  i_right,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/spdif_bmc_encoder.sv
// IEC 60958 subframe builder and biphase-mark line encoder, paced by a half-cell strobe.
// Optional SPDIF_CHSTAT_EN adds i_chstat, whose bit n becomes the C bit of frame n.
module spdif_bmc_encoder #(
    parameter int unsigned DATA_W           = 24,
    parameter int unsigned FRAMES_PER_BLOCK = 192
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                ena,
    spdif_bmc_encoder_if.slave  s_if,
`ifdef SPDIF_CHSTAT_EN
    input  logic [31:0]         i_chstat,
`endif
    output logic                o_spdif,
    output logic                o_underrun,
    output logic                o_block_start
);

    localparam int unsigned FW = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_BLOCK - 1);
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    typedef enum logic [1:0] {StIdle, StPre, StBits} state_e;

    state_e            state_q;
    logic [5:0]        hc_q;
    logic              right_q;
    logic [FW-1:0]     frame_q;
    logic              full_q;
    logic [DATA_W-1:0] hold_l_q, hold_r_q, work_l_q, work_r_q;
    logic              v_q, inv_q, spdif_q, underrun_q, block_start_q;
`ifdef SPDIF_CHSTAT_EN
    logic [31:0]       chstat_q;
`endif

    logic [7:0]        pat;
    logic [DATA_W-1:0] cur;
    logic [23:0]       sample;
    logic              c_bit;
    logic [31:0]       payload;
    logic [4:0]        slot_idx;
    logic              pre_lvl;
    logic              line_d;
    logic              frame_start;

    always_comb begin
        pat    = right_q ? PRE_W : ((frame_q == '0) ? PRE_B : PRE_M);
        cur    = right_q ? work_r_q : work_l_q;
        sample = 24'(cur) << (24 - DATA_W);
`ifdef SPDIF_CHSTAT_EN
        c_bit  = (32'(frame_q) < 32'd32) ? chstat_q[5'(frame_q)] : 1'b0;
`else
        c_bit  = 1'b0;
`endif
        // payload bit k carries slot k+4; bit 27 is even parity over the rest
        payload        = '0;
        payload[23:0]  = sample;
        payload[24]    = v_q;
        payload[25]    = 1'b0;
        payload[26]    = c_bit;
        payload[27]    = ^payload[26:0];
        slot_idx       = hc_q[5:1] - 5'd4;
        // preamble polarity is latched from the line level just before half-cell 0
        pre_lvl        = (hc_q == 6'd0) ? spdif_q : inv_q;
        if (state_q == StBits) begin
            line_d = hc_q[0] ? (spdif_q ^ payload[slot_idx]) : ~spdif_q;
        end else begin
            line_d = pat[~hc_q[2:0]] ^ pre_lvl;
        end
    end

    assign frame_start = ena && (state_q == StPre) && (hc_q == 6'd0) && !right_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            hc_q          <= '0;
            right_q       <= 1'b0;
            frame_q       <= '0;
            full_q        <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            work_l_q      <= '0;
            work_r_q      <= '0;
            v_q           <= 1'b0;
            inv_q         <= 1'b0;
            spdif_q       <= 1'b0;
            underrun_q    <= 1'b0;
            block_start_q <= 1'b0;
`ifdef SPDIF_CHSTAT_EN
            chstat_q      <= '0;
`endif
        end else begin
            underrun_q    <= 1'b0;
            block_start_q <= 1'b0;
            if (s_if.i_valid && !full_q) begin
                full_q   <= 1'b1;
                hold_l_q <= s_if.i_left;
                hold_r_q <= s_if.i_right;
            end
            if (ena) begin
                if (state_q == StIdle) begin
                    state_q <= StPre;
                    hc_q    <= '0;
                end else begin
                    spdif_q <= line_d;
                    hc_q    <= hc_q + 6'd1;
                    if (hc_q == 6'd0) inv_q <= spdif_q;
                    if (frame_start) begin
                        block_start_q <= (frame_q == '0);
                        if (full_q) begin
                            work_l_q <= hold_l_q;
                            work_r_q <= hold_r_q;
                            v_q      <= 1'b0;
                            full_q   <= 1'b0;
                        end else begin
                            work_l_q   <= '0;
                            work_r_q   <= '0;
                            v_q        <= 1'b1;
                            underrun_q <= 1'b1;
                        end
`ifdef SPDIF_CHSTAT_EN
                        if (frame_q == '0) chstat_q <= i_chstat;
`endif
                    end
                    if (hc_q == 6'd7) begin
                        state_q <= StBits;
                    end else if (hc_q == 6'd63) begin
                        state_q <= StPre;
                        right_q <= ~right_q;
                        if (right_q) begin
                            frame_q <= (frame_q == LAST_FRAME) ? '0 : frame_q + FW'(1);
                        end
                    end
                end
            end
        end
    end

    assign s_if.o_ready  = ~full_q;
    assign o_spdif       = spdif_q;
    assign o_underrun    = underrun_q;
    assign o_block_start = block_start_q;

endmodule

// File: tb/tb_spdif_bmc_encoder.sv
// Scoreboard bench for spdif_bmc_encoder: a frame-level model queues expected half-cells
// and pulses; a monitor pops and compares on every clk.
module tb_spdif_bmc_encoder;

    localparam int unsigned DW  = 24;
    localparam int          FPB = 192;
    localparam logic [7:0]  PB  = 8'b11101000;
    localparam logic [7:0]  PM  = 8'b11100010;
    localparam logic [7:0]  PW  = 8'b11100100;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    logic ena = 1'b0;
    logic o_spdif, o_underrun, o_block_start;
`ifdef SPDIF_CHSTAT_EN
    logic [31:0] chstat = 32'h0000_0005;
`endif

    spdif_bmc_encoder_if #(.DATA_W(DW)) s_if ();

    spdif_bmc_encoder #(.DATA_W(DW), .FRAMES_PER_BLOCK(FPB)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .ena          (ena),
        .s_if         (s_if),
`ifdef SPDIF_CHSTAT_EN
        .i_chstat     (chstat),
`endif
        .o_spdif      (o_spdif),
        .o_underrun   (o_underrun),
        .o_block_start(o_block_start)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic [1:0] pulse_q[$];
    int   ena_cnt = 0;
    int   frames_started = 0;
    int   h_cur = -1;
    bit   ena_on = 1'b0;
    int   period = 1;
    logic model_lvl = 1'b0;
    logic last_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot values 4..31 of one subframe, straight from the frame format rules.
    function automatic logic [31:0] make_word(input logic [DW-1:0] smp, input bit v, input bit c);
        logic [31:0] w;
        w        = '0;
        w[27:4]  = 24'(smp) << (24 - DW);
        w[28]    = v;
        w[29]    = 1'b0;
        w[30]    = c;
        w[31]    = ^w[30:4];
        return w;
    endfunction

    task automatic push_sub(input logic [7:0] pat, input logic [31:0] word);
        logic l0, a, b;
        l0 = model_lvl;
        for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i] ^ l0);
        model_lvl = pat[0] ^ l0;
        for (int s = 4; s < 32; s++) begin
            a = ~model_lvl;
            b = word[s] ? ~a : a;
            exp_q.push_back(a);
            exp_q.push_back(b);
            model_lvl = b;
        end
    endtask

    task automatic push_frame(input int n, input bit has, input logic [DW-1:0] l,
                              input logic [DW-1:0] r);
        int fb;
        bit c;
        logic [DW-1:0] ls, rs;
        fb = n % FPB;
        c  = 1'b0;
`ifdef SPDIF_CHSTAT_EN
        c  = (fb < 32) ? chstat[fb] : 1'b0;
`endif
        ls = has ? l : '0;
        rs = has ? r : '0;
        push_sub((fb == 0) ? PB : PM, make_word(ls, !has, c));
        push_sub(PW, make_word(rs, !has, c));
        pulse_q.push_back({!has, fb == 0});
    endtask

    task automatic offer(input int n, input logic [DW-1:0] l, input logic [DW-1:0] r);
        push_frame(n, 1'b1, l, r);
        @(negedge clk);
        check("ready_before_offer", s_if.o_ready, 1);
        s_if.i_valid = 1'b1;
        s_if.i_left  = l;
        s_if.i_right = r;
        @(posedge clk);
        #1;
        check("ready_after_transfer", s_if.o_ready, 0);
        @(negedge clk);
        s_if.i_valid = 1'b0;
        s_if.i_left  = DW'($urandom);
        s_if.i_right = DW'($urandom);
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_started < target && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("frame_start_timeout", 32'(frames_started >= target), 1);
    endtask

    // mode 0: directed opening frames; 1: always data; 2: random underruns
    task automatic run_phase(input int per, input int nframes, input int mode);
        int t;
        bit has;
        logic [DW-1:0] l, r;
        ena_on = 1'b0;
        period = per;
        @(negedge clk);
        i_rst = 1'b1;
        s_if.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        pulse_q.delete();
        model_lvl = 1'b0;
        i_rst = 1'b0;
        for (int n = 0; n < nframes; n++) begin
            if (n > 0) wait_frames(n);
            has = 1'b1;
            l = DW'($urandom);
            r = DW'($urandom);
            if (mode == 0) begin
                if (n == 0) has = 1'b0;
                if (n == 1) begin l = 24'h000001; r = 24'h000000; end
                if (n == 2) l = 24'h800000;
            end else if (mode == 2) begin
                has = ($urandom_range(0, 3) != 0);
            end
            if (has) offer(n, l, r);
            else push_frame(n, 1'b0, '0, '0);
            if (n == 0) ena_on = 1'b1;
        end
        wait_frames(nframes);
        // abort mid-way through the right subframe of the last frame
        t = 0;
        while (h_cur != (nframes - 1) * 128 + 94 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("reach_right_halfcell_30", 32'(h_cur), 32'((nframes - 1) * 128 + 94));
        i_rst  = 1'b1;
        ena_on = 1'b0;
        exp_q.delete();
        pulse_q.delete();
        @(posedge clk);
        #2;
        check("reset_line_low", o_spdif, 0);
        check("reset_ready_high", s_if.o_ready, 1);
        check("reset_underrun_low", o_underrun, 0);
        check("reset_block_start_low", o_block_start, 0);
    endtask

    // Half-cell strobe generator
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!ena_on) begin
                ena = 1'b0;
                cnt = 0;
            end else begin
                ena = (cnt == 0);
                cnt = (cnt + 1) % period;
            end
        end
    end

    // Monitor: compares line and pulses against the queued expectations
    initial begin
        logic e, r, fs;
        logic [1:0] p;
        forever begin
            @(posedge clk);
            e = ena;
            r = i_rst;
            #1;
            if (r) begin
                ena_cnt = 0;
                frames_started = 0;
                h_cur = -1;
                last_exp = 1'b0;
            end else begin
                fs = 1'b0;
                if (e) begin
                    ena_cnt++;
                    if (ena_cnt == 1) begin
                        check("idle_exit_line", o_spdif, 0);
                    end else begin
                        h_cur = ena_cnt - 2;
                        fs = (h_cur % 128 == 0);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL stream_starved: got empty queue required data at %0t",
                                     $time);
                        end else begin
                            last_exp = exp_q.pop_front();
                            check("line_halfcell", o_spdif, last_exp);
                        end
                    end
                end else begin
                    check("line_hold", o_spdif, last_exp);
                end
                if (fs) begin
                    if (pulse_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pulse_starved: got empty queue required entry at %0t",
                                 $time);
                    end else begin
                        p = pulse_q.pop_front();
                        check("frame_underrun", o_underrun, p[1]);
                        check("frame_block_start", o_block_start, p[0]);
                    end
                    check("ready_after_frame_start", s_if.o_ready, 1);
                    frames_started++;
                end else begin
                    check("underrun_quiet", o_underrun, 0);
                    check("block_start_quiet", o_block_start, 0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.i_valid = 1'b0;
        s_if.i_left  = '0;
        s_if.i_right = '0;
        repeat (3) @(negedge clk);
        check("por_line_low", o_spdif, 0);
        check("por_ready_high", s_if.o_ready, 1);
        run_phase(4, 4, 0);
        run_phase(1, 194, 1);
        run_phase(3, 6, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
